// File: rtl/mvu_wmem_port_arbiter_pkg.sv
// Shared types and constants for the MVU weight-RAM port arbiter.
//   arb_state_e      lock-tracking state of the round-robin arbiter
//   wmem_req_t       canonical 32-bit weight-RAM request bundle
//   arb_idx_width()  index width for a given requester count (min 1 bit)
package mvu_wmem_port_arbiter_pkg;

    localparam int unsigned ArbMaxHoldDefault = 16;

    localparam int unsigned WmemAddrWidth = 32;
    localparam int unsigned WmemDataWidth = 32;
    localparam int unsigned WmemBeWidth   = WmemDataWidth / 8;

    typedef enum logic [1:0] {
        ARB_RR       = 2'd0,
        ARB_LOCKED   = 2'd1,
        ARB_COOLDOWN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                     we;
        logic [WmemAddrWidth-1:0] addr;
        logic [WmemBeWidth-1:0]   be;
        logic [WmemDataWidth-1:0] wdata;
    } wmem_req_t;

    function automatic int unsigned arb_idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/mvu_wmem_port_arbiter_if.sv
// Requester-side and memory-side bus of the weight-RAM port arbiter.
//   req/lock/we/addr/be/wdata  flattened per-requester request fields
//   gnt/rvalid/rdata           per-requester grant and response
//   mem_*                      single shared memory port
// modport slave : the arbiter
// modport master: requesters + memory model driving the arbiter
interface mvu_wmem_port_arbiter_if #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) ();
    localparam int unsigned BeWidth = DataWidth / 8;

    logic [NumReq-1:0]           req;
    logic [NumReq-1:0]           lock;
    logic [NumReq-1:0]           we;
    logic [NumReq*AddrWidth-1:0] addr;
    logic [NumReq*BeWidth-1:0]   be;
    logic [NumReq*DataWidth-1:0] wdata;
    logic [NumReq-1:0]           gnt;
    logic [NumReq-1:0]           rvalid;
    logic [DataWidth-1:0]        rdata;

    logic                        mem_req;
    logic                        mem_we;
    logic [AddrWidth-1:0]        mem_addr;
    logic [BeWidth-1:0]          mem_be;
    logic [DataWidth-1:0]        mem_wdata;
    logic [DataWidth-1:0]        mem_rdata;

    modport slave (
        input  req, lock, we, addr, be, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req, lock, we, addr, be, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mvu_wmem_port_arbiter_rr_lock_arb.sv
// Round-robin arbiter with bounded ownership lock. Control only, no datapath.
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i         per-requester request
//   lock_i        per-requester request to keep ownership next cycle
//   gnt_o         one-hot grant (combinational, forced to 0 in reset)
//   win_idx_o     winner index for the datapath mux (0 when nobody requests)
//
// state        | meaning
// ARB_RR       | no owner, plain round-robin from ptr_q
// ARB_LOCKED   | owner_q wins whenever it requests, hold_cnt_q grants so far
// ARB_COOLDOWN | owner_q just hit MaxHold; round-robin and owner_q may not re-lock
module mvu_wmem_port_arbiter_rr_lock_arb
    import mvu_wmem_port_arbiter_pkg::*;
#(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned MaxHold = ArbMaxHoldDefault
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0]                   lock_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [arb_idx_width(NumReq)-1:0]    win_idx_o
);
    localparam int unsigned IdxWidth  = arb_idx_width(NumReq);
    localparam int unsigned HoldWidth = $clog2(MaxHold + 1);

    typedef logic [IdxWidth-1:0]  idx_t;
    typedef logic [HoldWidth-1:0] hold_t;

    localparam idx_t  LastIdx   = idx_t'(NumReq - 1);
    localparam hold_t HoldLimit = hold_t'(MaxHold);

    arb_state_e state_q, state_d;
    idx_t       ptr_q, ptr_d;
    idx_t       owner_q, owner_d;
    hold_t      hold_cnt_q, hold_cnt_d;

    idx_t       cand;
    idx_t       rr_idx;
    idx_t       win_idx;
    hold_t      hold_inc;
    logic       rr_found;
    logic       owner_wins;
    logic       win_valid;
    logic       may_lock;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = idx_t'((32'(ptr_q) + i) % NumReq);
            if (!rr_found && req_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end

        owner_wins = (state_q == ARB_LOCKED) && req_i[owner_q];
        win_valid  = owner_wins || rr_found;
        win_idx    = owner_wins ? owner_q : rr_idx;

        gnt_o = '0;
        if (win_valid && !rst_i) begin
            gnt_o[win_idx] = 1'b1;
        end

        // Any grant that is not a continuing lock starts a fresh run of one.
        hold_inc = owner_wins ? hold_cnt_q + hold_t'(1) : hold_t'(1);
        may_lock = lock_i[win_idx] &&
                   !((state_q == ARB_COOLDOWN) && (win_idx == owner_q));

        state_d    = ARB_RR;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = '0;
        if (win_valid) begin
            ptr_d = (win_idx == LastIdx) ? '0 : win_idx + idx_t'(1);
            if (may_lock) begin
                owner_d = win_idx;
                // Reaching the limit still grants this cycle but forces rotation.
                if (hold_inc >= HoldLimit) begin
                    state_d = ARB_COOLDOWN;
                end else begin
                    state_d    = ARB_LOCKED;
                    hold_cnt_d = hold_inc;
                end
            end
        end
    end

    assign win_idx_o = win_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_RR;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: rtl/mvu_wmem_port_arbiter.sv
// Shares one single-port MVU weight-RAM between NumReq requesters.
// Round-robin grant with bounded lock, winner's request muxed onto mem_*,
// and a fixed-latency pipe routing each response back to its issuer.
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus           slave side of mvu_wmem_port_arbiter_if:
//                 req/lock/we/addr/be/wdata in, gnt/rvalid/rdata out,
//                 mem_req/we/addr/be/wdata out, mem_rdata in
module mvu_wmem_port_arbiter
    import mvu_wmem_port_arbiter_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned MaxHold     = ArbMaxHoldDefault
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mvu_wmem_port_arbiter_if.slave bus
);
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned IdxWidth = arb_idx_width(NumReq);

    typedef logic [IdxWidth-1:0] idx_t;

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [BeWidth-1:0]   be;
        logic [DataWidth-1:0] wdata;
    } req_bus_t;

    req_bus_t          req_arr [NumReq];
    req_bus_t          win_req;
    logic [NumReq-1:0] gnt;
    idx_t              win_idx;

    // One-hot grant per pipe stage; a non-zero entry is the valid flag.
    logic [NumReq-1:0] rsp_pipe_q [ReadLatency];
    logic [NumReq-1:0] rsp_pipe_d [ReadLatency];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign req_arr[g] = {bus.we[g],
                             bus.addr[g*AddrWidth +: AddrWidth],
                             bus.be[g*BeWidth +: BeWidth],
                             bus.wdata[g*DataWidth +: DataWidth]};
    end

    mvu_wmem_port_arbiter_rr_lock_arb #(
        .NumReq  (NumReq),
        .MaxHold (MaxHold)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (bus.req),
        .lock_i    (bus.lock),
        .gnt_o     (gnt),
        .win_idx_o (win_idx)
    );

    // With no request the arbiter reports index 0, so mem_* show requester 0.
    assign win_req       = req_arr[win_idx];
    assign bus.gnt       = gnt;
    assign bus.mem_req   = |gnt;
    assign bus.mem_we    = win_req.we;
    assign bus.mem_addr  = win_req.addr;
    assign bus.mem_be    = win_req.be;
    assign bus.mem_wdata = win_req.wdata;

    always_comb begin
        rsp_pipe_d[0] = gnt;
        for (int unsigned i = 1; i < ReadLatency; i++) begin
            rsp_pipe_d[i] = rsp_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                rsp_pipe_q[i] <= '0;
            end
        end else begin
            rsp_pipe_q <= rsp_pipe_d;
        end
    end

    assign bus.rvalid = rsp_pipe_q[ReadLatency-1];
    assign bus.rdata  = bus.mem_rdata;

    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt));
    a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.rvalid));
    a_gnt_has_req : assert property (@(posedge clk_i) disable iff (rst_i)
        (gnt & ~bus.req) == '0);

endmodule
